// File: rtl/axis_weight_scaler_if.sv
// Stream bundle shared by the scaler's input and output ports.
//
// Handshake: a beat transfers on a rising clock edge where tvalid and tready
// are both 1. While the source holds tvalid=1 and the sink has not yet
// accepted, tdata/tkeep/tlast stay constant. tready may depend
// combinationally on the sink's state. tvalid never depends on tready.
interface axis_weight_scaler_if #(
  parameter int TDW = 128
) ();
  logic [TDW-1:0]   tdata;
  logic [TDW/8-1:0] tkeep;
  logic             tvalid;
  logic             tlast;
  logic             tready;

  modport master (
    output tdata,
    output tkeep,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tkeep,
    input  tvalid,
    input  tlast,
    output tready
  );
endinterface

// File: rtl/axis_weight_scaler.sv
// Two-stage stream scaler. Each DW-bit signed lane is multiplied by a signed
// fixed-point weight, rounded half-up, and saturated. The weight and bypass
// mode are latched once at the start of each packet.
// Stage 1 registers the accepted beat together with its packet weight.
// Stage 2 registers the scaled result, which drives m_axis directly.
module axis_weight_scaler #(
  parameter int LANES = 16,
  parameter int DW    = 8,
  parameter int WW    = 8,
  parameter int FRAC  = 7
) (
  input  logic                        CLK,
  input  logic                        RST,
  axis_weight_scaler_if.slave         s_axis,
  axis_weight_scaler_if.master        m_axis,
  input  logic [WW-1:0]               bWeight,
  input  logic                        bWeight_valid,
  input  logic                        bypass,
  output logic [15:0]                 sat_count,
  output logic [15:0]                 pkt_count,
  output logic                        dbg_in_pkt_o
);

  localparam int TW = LANES * DW;
  localparam int KW = TW / 8;
  // One guard bit above the full product, so adding the rounding constant
  // cannot overflow.
  localparam int PW = DW + WW + 1;

  localparam logic signed [PW-1:0] RND  = PW'(1) << (FRAC - 1);
  localparam logic signed [PW-1:0] MAXV = PW'((2 ** (DW - 1)) - 1);
  localparam logic signed [PW-1:0] MINV = PW'(-(2 ** (DW - 1)));

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_IN_PKT = 1'b1
  } pkt_state_e;

  pkt_state_e state_q, state_d;

  logic [WW-1:0] shadow_q;
  logic [WW-1:0] act_weight_q;
  logic          act_bypass_q;
  logic [WW-1:0] eff_weight;
  logic          eff_bypass;
  logic          load_active;

  logic          s1_valid_q;
  logic [TW-1:0] s1_data_q;
  logic [KW-1:0] s1_keep_q;
  logic          s1_last_q;
  logic [WW-1:0] s1_weight_q;
  logic          s1_bypass_q;

  logic          m_valid_q;
  logic [TW-1:0] m_data_q;
  logic [KW-1:0] m_keep_q;
  logic          m_last_q;
  logic          m_sat_q;

  logic [15:0]   sat_cnt_q;
  logic [15:0]   pkt_cnt_q;

  logic          en;
  logic          s_fire;
  logic          m_fire;

  logic [TW-1:0]    scaled_w;
  logic [LANES-1:0] lane_sat_w;

  // Scale one lane. Bit DW of the result flags saturation; the low DW bits
  // hold the value.
  function automatic logic [DW:0] scale_lane(
    input logic signed [DW-1:0] sample,
    input logic signed [WW-1:0] weight
  );
    logic signed [PW-1:0] s_ext;
    logic signed [PW-1:0] w_ext;
    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] shifted;
    s_ext   = {{(PW-DW){sample[DW-1]}}, sample};
    w_ext   = {{(PW-WW){weight[WW-1]}}, weight};
    prod    = s_ext * w_ext;
    // Adding half an LSB before the arithmetic shift gives round-half-up.
    shifted = (prod + RND) >>> FRAC;
    if (shifted > MAXV) begin
      scale_lane = {1'b1, MAXV[DW-1:0]};
    end else if (shifted < MINV) begin
      scale_lane = {1'b1, MINV[DW-1:0]};
    end else begin
      scale_lane = {1'b0, shifted[DW-1:0]};
    end
  endfunction

  // The whole pipeline advances together when the output slot is free or
  // is being drained this cycle.
  assign en            = !m_valid_q || m_axis.tready;
  assign s_axis.tready = en;
  assign s_fire        = s_axis.tvalid && en;
  assign m_fire        = m_valid_q && m_axis.tready;

  // Shadow weight captures every load strobe, whatever the packet state.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      shadow_q <= '0;
    end else if (bWeight_valid) begin
      shadow_q <= bWeight;
    end
  end

  // Packet state register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next packet state, and the weight/bypass that apply to the beat now at
  // the input. On a first beat, a coinciding strobe takes priority over the
  // shadow register.
  always_comb begin
    state_d     = state_q;
    load_active = 1'b0;
    eff_weight  = act_weight_q;
    eff_bypass  = act_bypass_q;
    case (state_q)
      ST_IDLE: begin
        eff_weight = bWeight_valid ? bWeight : shadow_q;
        eff_bypass = bypass;
        if (s_fire) begin
          load_active = 1'b1;
          state_d     = s_axis.tlast ? ST_IDLE : ST_IN_PKT;
        end
      end
      ST_IN_PKT: begin
        if (s_fire && s_axis.tlast) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Latch the per-packet weight and bypass when a packet's first beat is
  // accepted.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      act_weight_q <= '0;
      act_bypass_q <= 1'b0;
    end else if (load_active) begin
      act_weight_q <= eff_weight;
      act_bypass_q <= eff_bypass;
    end
  end

  // Stage 1: capture the accepted beat with its packet weight. A bubble
  // enters as valid=0.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_keep_q   <= '0;
      s1_last_q   <= 1'b0;
      s1_weight_q <= '0;
      s1_bypass_q <= 1'b0;
    end else if (en) begin
      s1_valid_q <= s_axis.tvalid;
      if (s_axis.tvalid) begin
        s1_data_q   <= s_axis.tdata;
        s1_keep_q   <= s_axis.tkeep;
        s1_last_q   <= s_axis.tlast;
        s1_weight_q <= eff_weight;
        s1_bypass_q <= eff_bypass;
      end
    end
  end

  // Per-lane arithmetic. Bypass forwards the sample untouched and never
  // flags saturation.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [DW:0] res;
    assign res                  = scale_lane(s1_data_q[k*DW +: DW], s1_weight_q);
    assign scaled_w[k*DW +: DW] = s1_bypass_q ? s1_data_q[k*DW +: DW] : res[DW-1:0];
    assign lane_sat_w[k]        = !s1_bypass_q && res[DW];
  end

  // Stage 2: the output register. It holds while stalled, which keeps the
  // beat stable until it is accepted.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_keep_q  <= '0;
      m_last_q  <= 1'b0;
      m_sat_q   <= 1'b0;
    end else if (en) begin
      m_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        m_data_q <= scaled_w;
        m_keep_q <= s1_keep_q;
        m_last_q <= s1_last_q;
        m_sat_q  <= |lane_sat_w;
      end
    end
  end

  // Output-side statistics. The saturation count sticks at all-ones; the
  // packet count wraps.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sat_cnt_q <= '0;
      pkt_cnt_q <= '0;
    end else begin
      if (m_fire && m_sat_q && (sat_cnt_q != 16'hFFFF)) begin
        sat_cnt_q <= sat_cnt_q + 16'd1;
      end
      if (m_fire && m_last_q) begin
        pkt_cnt_q <= pkt_cnt_q + 16'd1;
      end
    end
  end

  assign m_axis.tvalid = m_valid_q;
  assign m_axis.tdata  = m_data_q;
  assign m_axis.tkeep  = m_keep_q;
  assign m_axis.tlast  = m_last_q;
  assign sat_count     = sat_cnt_q;
  assign pkt_count     = pkt_cnt_q;
  assign dbg_in_pkt_o  = (state_q == ST_IN_PKT);

endmodule
